// File: rtl/int_calc16.sv
// int_calc16: 16-bit unsigned integer calculator with a registered result.
// All eight functions are evaluated in parallel from A/B. The opcode picks one
// result, and it is loaded into sum/sign on an enabled rising edge.
module int_calc16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  operation,
   input  logic        enable,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        sign,
   output logic [15:0] sum
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_EXP = 3'd4;
   localparam logic [2:0] OP_LOG = 3'd5;
   localparam logic [2:0] OP_POW = 3'd6;
   localparam logic [2:0] OP_MOD = 3'd7;

   logic [15:0] sum_q, sum_d;
   logic        sign_q, sign_d;

   logic [15:0] add_res;
   logic [15:0] sub_res;
   logic        sub_neg;
   logic [15:0] mul_res;
   logic [15:0] div_res;
   logic [15:0] exp_res;
   logic [15:0] log_res;
   logic [15:0] mod_res;

   // Power chain: square-and-multiply unrolled over all 16 exponent bits.
   // pow_acc[k] holds the partial product after exponent bits [k-1:0].
   // pow_base[k] holds A^(2^k).
   logic [15:0] pow_acc  [0:16];
   logic [15:0] pow_base [0:15];

   assign pow_acc[0]  = 16'd1;
   assign pow_base[0] = A;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_pow
         assign pow_acc[gi+1] = B[gi] ? (pow_acc[gi] * pow_base[gi]) : pow_acc[gi];
         if (gi < 15) begin : g_sq
            assign pow_base[gi+1] = pow_base[gi] * pow_base[gi];
         end
      end
   endgenerate

   // Parallel evaluation of the non-chained functions.
   always_comb begin
      add_res = A + B;
      sub_neg = (A < B);
      sub_res = sub_neg ? (B - A) : (A - B);
      mul_res = A * B;
      // A zero divisor saturates the quotient. The remainder passes A through.
      div_res = (B == 16'd0) ? 16'hFFFF : (A / B);
      mod_res = (B == 16'd0) ? A : (A % B);
      // Any shift of 16 or more clears every bit of a 16-bit value.
      exp_res = (B >= 16'd16) ? 16'd0 : (A << B[3:0]);
      // floor(log10(A)) equals the decimal digit count minus one. A = 0 maps to 0.
      if (A >= 16'd10000)      log_res = 16'd4;
      else if (A >= 16'd1000)  log_res = 16'd3;
      else if (A >= 16'd100)   log_res = 16'd2;
      else if (A >= 16'd10)    log_res = 16'd1;
      else                     log_res = 16'd0;
   end

   // Opcode selection of the next result. Only SUB can produce a set sign flag.
   always_comb begin
      sum_d  = add_res;
      sign_d = 1'b0;
      case (operation)
         OP_ADD: sum_d = add_res;
         OP_SUB: begin
            sum_d  = sub_res;
            sign_d = sub_neg;
         end
         OP_MUL: sum_d = mul_res;
         OP_DIV: sum_d = div_res;
         OP_EXP: sum_d = exp_res;
         OP_LOG: sum_d = log_res;
         OP_POW: sum_d = pow_acc[16];
         OP_MOD: sum_d = mod_res;
         default: sum_d = add_res;
      endcase
   end

   // Result register: reset wins over enable, and the register holds while enable is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= 16'h0000;
         sign_q <= 1'b0;
      end else if (enable) begin
         sum_q  <= sum_d;
         sign_q <= sign_d;
      end
   end

   assign sum  = sum_q;
   assign sign = sign_q;

endmodule

// File: tb/tb_int_calc16.sv
// Directed testbench for int_calc16. Each step drives one operation and checks
// sum/sign 1 time unit after the loading edge.
module tb_int_calc16;

   logic        clk;
   logic        rst;
   logic [2:0]  operation;
   logic        enable;
   logic [15:0] A;
   logic [15:0] B;
   logic        sign;
   logic [15:0] sum;

   int checks = 0;
   int errors = 0;

   int_calc16 dut (
      .clk       (clk),
      .rst       (rst),
      .operation (operation),
      .enable    (enable),
      .A         (A),
      .B         (B),
      .sign      (sign),
      .sum       (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so that the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [15:0] exp_sum, input logic exp_sign);
      checks++;
      assert (sum === exp_sum) else begin
         errors++;
         $error("FAIL %s sum: observed %0d expected %0d", tag, sum, exp_sum);
      end
      checks++;
      assert (sign === exp_sign) else begin
         errors++;
         $error("FAIL %s sign: observed %0b expected %0b", tag, sign, exp_sign);
      end
      $display("step %-12s op=%0d A=%0d B=%0d -> sum=%0d sign=%0b", tag, operation, A, B, sum, sign);
   endtask

   // Drive one enabled operation, clock it in, and check the result.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_sum, input logic exp_sign);
      operation = op;
      A         = a;
      B         = b;
      enable    = 1'b1;
      @(posedge clk);
      #1;
      check(tag, exp_sum, exp_sign);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; operation = 3'd0; A = 16'd0; B = 16'd0;
      @(posedge clk); #1;
      check("reset", 16'd0, 1'b0);
      rst = 1'b0;

      do_op("add", 3'd0, 16'd25, 16'd30, 16'd55, 1'b0);
      do_op("add_wrap", 3'd0, 16'd65535, 16'd1, 16'd0, 1'b0);
      do_op("sub_neg", 3'd1, 16'd25, 16'd30, 16'd5, 1'b1);
      do_op("sub_pos", 3'd1, 16'd20, 16'd5, 16'd15, 1'b0);
      do_op("sub_eq", 3'd1, 16'd7, 16'd7, 16'd0, 1'b0);
      do_op("mul", 3'd2, 16'd4, 16'd5, 16'd20, 1'b0);
      do_op("mul_trunc", 3'd2, 16'd300, 16'd300, 16'd24464, 1'b0);
      do_op("div", 3'd3, 16'd10, 16'd2, 16'd5, 1'b0);
      do_op("div_zero", 3'd3, 16'd10, 16'd0, 16'd65535, 1'b0);
      do_op("mod0", 3'd7, 16'd10, 16'd2, 16'd0, 1'b0);
      do_op("mod1", 3'd7, 16'd10, 16'd3, 16'd1, 1'b0);
      do_op("mod_zero", 3'd7, 16'd10, 16'd0, 16'd10, 1'b0);
      do_op("exp", 3'd4, 16'd10, 16'd2, 16'd40, 1'b0);
      do_op("exp_big", 3'd4, 16'd1, 16'd16, 16'd0, 1'b0);
      do_op("log_10", 3'd5, 16'd10, 16'd7, 16'd1, 1'b0);
      do_op("log_9", 3'd5, 16'd9, 16'd0, 16'd0, 1'b0);
      do_op("log_0", 3'd5, 16'd0, 16'd3, 16'd0, 1'b0);
      do_op("log_max", 3'd5, 16'd65535, 16'd0, 16'd4, 1'b0);
      do_op("log_999", 3'd5, 16'd999, 16'd0, 16'd2, 1'b0);
      do_op("log_1000", 3'd5, 16'd1000, 16'd0, 16'd3, 1'b0);
      do_op("pow_2_2", 3'd6, 16'd2, 16'd2, 16'd4, 1'b0);
      do_op("pow_3_4", 3'd6, 16'd3, 16'd4, 16'd81, 1'b0);
      do_op("pow_2_16", 3'd6, 16'd2, 16'd16, 16'd0, 1'b0);
      do_op("pow_0_0", 3'd6, 16'd0, 16'd0, 16'd1, 1'b0);
      do_op("pow_3_5", 3'd6, 16'd3, 16'd5, 16'd243, 1'b0);

      // Hold: load 55, then vary the inputs with enable low.
      do_op("hold_load", 3'd0, 16'd25, 16'd30, 16'd55, 1'b0);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         operation = 3'd1;
         A = 16'd3 + 16'(i);
         B = 16'd100;
         @(posedge clk); #1;
         check("hold", 16'd55, 1'b0);
      end

      // Back-to-back operations on consecutive edges.
      do_op("b2b_mul", 3'd2, 16'd4, 16'd5, 16'd20, 1'b0);
      do_op("b2b_div", 3'd3, 16'd100, 16'd7, 16'd14, 1'b0);

      // Reset takes priority over enable and clears a set sign flag.
      do_op("pre_rst", 3'd1, 16'd1, 16'd9, 16'd8, 1'b1);
      rst = 1'b1;
      do_op("rst_prio", 3'd0, 16'd1, 16'd2, 16'd0, 1'b0);
      rst = 1'b0;
      do_op("post_rst", 3'd0, 16'd1, 16'd2, 16'd3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
